ebus_io_slave: RTL

//  Generic EBUS I/O device slave; consumes the EBUS the CPU's EBUS mux drives (cs, func, demand, data).

---
 rtl/ebus_pkg.sv | 68 ++++++
 rtl/ebus_slave_fifo.sv | 81 ++++++++
 rtl/ebus_io_slave.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ebus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ebus_pkg
// Purpose  : Shared types and bit positions for the EBUS I/O slave: the
//            function-code enum, the slave FSM states, CONO/CONI field
//            positions and the backplane driver record.
// Revision : 1.0  initial release
// ============================================================================
package ebus_pkg;

  // Backplane driver record fed into the top-level EBUS data mux.
  // Bits are numbered big-endian: bit 0 is the MSB and bit 35 is the LSB.
  typedef struct packed {
    logic        driving;
    logic [0:35] data;
  } tEBUSdriver;

  // Function codes carried on ebusFunc[0:2]. Codes 5..7 are not decoded.
  typedef enum logic [2:0] {
    FN_CONO   = 3'd0,
    FN_CONI   = 3'd1,
    FN_DATAO  = 3'd2,
    FN_DATAI  = 3'd3,
    FN_PISERV = 3'd4
  } tEBUSfunc;

  // Slave handshake states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2
  } tSlaveState;

  // CONO field positions (EBUS bit numbering, 0 = MSB).
  localparam int CONO_PI_MSB   = 33;
  localparam int CONO_PI_LSB   = 35;
  localparam int CONO_INT_EN   = 32;
  localparam int CONO_CLR_PEND = 31;
  localparam int CONO_CLR_FIFO = 30;

  // CONI field positions (EBUS bit numbering, 0 = MSB).
  localparam int CONI_FULL     = 28;
  localparam int CONI_EMPTY    = 29;
  localparam int CONI_PEND     = 30;
  localparam int CONI_INT_EN   = 32;

  // Assemble the CONI status word; unlisted bits read as zero.
  function automatic logic [0:35] coni_word(
    input logic [0:17] status,
    input logic        full,
    input logic        empty,
    input logic        pend,
    input logic        int_en,
    input logic [0:2]  pi_level
  );
    logic [0:35] w;
    w                           = '0;
    w[0:17]                     = status;
    w[CONI_FULL]                = full;
    w[CONI_EMPTY]               = empty;
    w[CONI_PEND]                = pend;
    w[CONI_INT_EN]              = int_en;
    w[CONO_PI_MSB:CONO_PI_LSB]  = pi_level;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ebus_slave_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ebus_slave_fifo
// Purpose  : Small register FIFO carrying DATAO words toward the device core.
//            Clear has priority over push/pop; pointers wrap mod DEPTH.
// Revision : 1.0  initial release
// ============================================================================
module ebus_slave_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // Next pointer/count/storage; a clear discards everything, including a pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // FIFO state registers; reset empties the FIFO and zeroes its contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ebus_io_slave.sv
`default_nettype none
// ============================================================================
// Module   : ebus_io_slave
// Purpose  : Generic EBUS I/O device slave. Decodes CONO/CONI/DATAO/DATAI/
//            PI-serve for one device code, runs the demand/xfer handshake,
//            queues DATAO words for the device and raises a PI request.
// Revision : 1.0  initial release
// ============================================================================
module ebus_io_slave
  import ebus_pkg::*;
#(
  parameter logic [0:6]  DEV_CS     = 7'o14,
  parameter int          FIFO_DEPTH = 4,
  parameter int          XFER_DLY   = 2,
  parameter logic [17:0] VECTOR     = 18'o40
) (
  input  logic        clk,
  input  logic        crobar,
  input  logic [0:6]  ebusCS,
  input  logic [0:2]  ebusFunc,
  input  logic        ebusDemand,
  input  logic [0:35] ebusDataIn,
  output tEBUSdriver  EBUSdriver,
  output logic        ebusXfer,
  output logic [0:7]  ebusPI,
  output logic        devRxValid,
  output logic [0:35] devRxData,
  input  logic        devRxReady,
  input  logic [0:35] devTxData,
  input  logic [0:17] devStatus,
  input  logic        devIntReq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  tSlaveState  state_q,    state_d;
  tEBUSfunc    func_q,     func_d;
  logic [3:0]  dly_q,      dly_d;
  logic        xfer_q,     xfer_d;
  logic        drv_q,      drv_d;
  logic [0:35] data_q,     data_d;
  logic [0:2]  pi_level_q, pi_level_d;
  logic        int_en_q,   int_en_d;
  logic        pending_q,  pending_d;
  logic [0:7]  pi_q,       pi_d;

  logic             fifo_push;
  logic             fifo_clr;
  logic             pend_clr;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [35:0]      fifo_head;
  logic             fifo_at_depth;
  logic             cmd_hit;

  assign cmd_hit       = ebusDemand && (ebusCS == DEV_CS) && (ebusFunc <= 3'd4);
  assign fifo_at_depth = (fifo_count == CNT_W'(FIFO_DEPTH));

  ebus_slave_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (36)
  ) u_fifo (
    .clk       (clk),
    .rst       (crobar),
    .push      (fifo_push),
    .push_data (ebusDataIn),
    .pop       (devRxReady),
    .clear     (fifo_clr),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Handshake sequencing, register side effects at xfer-rise, PI request.
  always_comb begin
    state_d    = state_q;
    func_d     = func_q;
    dly_d      = dly_q;
    xfer_d     = xfer_q;
    drv_d      = drv_q;
    data_d     = data_q;
    pi_level_d = pi_level_q;
    int_en_d   = int_en_q;
    pending_d  = pending_q;
    pi_d       = '0;
    fifo_push  = 1'b0;
    fifo_clr   = 1'b0;
    pend_clr   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_hit) begin
          state_d = WAIT;
          func_d  = tEBUSfunc'(ebusFunc);
          dly_d   = 4'(XFER_DLY);
        end
      end

      WAIT: begin
        if (!ebusDemand) begin
          // CPU gave up before acknowledge: abandon with no side effects.
          state_d = IDLE;
        end else if (dly_q != 4'd0) begin
          dly_d = dly_q - 4'd1;
        end else if (func_q == FN_DATAO && fifo_at_depth) begin
          // No room for the word: hold off the acknowledge.
          state_d = WAIT;
        end else begin
          state_d = XFER;
          xfer_d  = 1'b1;
          case (func_q)
            FN_CONO: begin
              pi_level_d = ebusDataIn[CONO_PI_MSB:CONO_PI_LSB];
              int_en_d   = ebusDataIn[CONO_INT_EN];
              pend_clr   = ebusDataIn[CONO_CLR_PEND];
              fifo_clr   = ebusDataIn[CONO_CLR_FIFO];
            end
            FN_CONI: begin
              drv_d  = 1'b1;
              data_d = coni_word(devStatus, fifo_full, fifo_empty,
                                 pending_q, int_en_q, pi_level_q);
            end
            FN_DATAO: begin
              fifo_push = 1'b1;
            end
            FN_DATAI: begin
              drv_d  = 1'b1;
              data_d = devTxData;
            end
            FN_PISERV: begin
              drv_d  = 1'b1;
              data_d = {18'd0, VECTOR};
            end
            default: begin
              state_d = IDLE;
              xfer_d  = 1'b0;
            end
          endcase
        end
      end

      XFER: begin
        if (!ebusDemand) begin
          state_d = IDLE;
          xfer_d  = 1'b0;
          drv_d   = 1'b0;
          data_d  = '0;
          // A served interrupt is retired as the CPU releases the bus.
          if (func_q == FN_PISERV) begin
            pend_clr = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        xfer_d  = 1'b0;
        drv_d   = 1'b0;
        data_d  = '0;
      end
    endcase

    // A new device request outranks any clear in the same cycle.
    if (pend_clr) begin
      pending_d = 1'b0;
    end
    if (devIntReq) begin
      pending_d = 1'b1;
    end

    // Request line follows the state being written this cycle.
    if (pending_d && int_en_d && (pi_level_d != 3'd0)) begin
      pi_d[pi_level_d] = 1'b1;
    end
  end

  // Slave state registers; crobar returns everything to idle at once.
  always_ff @(posedge clk or posedge crobar) begin
    if (crobar) begin
      state_q    <= IDLE;
      func_q     <= FN_CONO;
      dly_q      <= '0;
      xfer_q     <= 1'b0;
      drv_q      <= 1'b0;
      data_q     <= '0;
      pi_level_q <= '0;
      int_en_q   <= 1'b0;
      pending_q  <= 1'b0;
      pi_q       <= '0;
    end else begin
      state_q    <= state_d;
      func_q     <= func_d;
      dly_q      <= dly_d;
      xfer_q     <= xfer_d;
      drv_q      <= drv_d;
      data_q     <= data_d;
      pi_level_q <= pi_level_d;
      int_en_q   <= int_en_d;
      pending_q  <= pending_d;
      pi_q       <= pi_d;
    end
  end

  assign EBUSdriver.driving = drv_q;
  assign EBUSdriver.data    = data_q;
  assign ebusXfer           = xfer_q;
  assign ebusPI             = pi_q;
  assign devRxValid         = !fifo_empty;
  assign devRxData          = fifo_head;

endmodule
`default_nettype wire
